// File: rtl/serial_adder_sequencer.sv
// Operand FIFO, start/done sequencer and result holder for the 8-bit serial adder.
// Define SEQ_TIMEOUT_EN to enable the WAIT-state watchdog and sticky err flag.
`timescale 1ns/1ps
module serial_adder_sequencer #(
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_sum,
    output logic [CNT_W-1:0] ops_count,
    output logic             busy,
    output logic             err,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    output logic             add_start,
    output logic             add_rst,
    input  logic [7:0]       add_c,
    input  logic             add_done
);

    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("serial_adder_sequencer: bad parameter");
    end

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t state, state_nx;

    logic [7:0]    mem_a [FIFO_DEPTH];
    logic [7:0]    mem_b [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt;
    logic          push, pop, not_empty, tmo_hit;

    assign not_empty = (cnt != '0);
    assign in_ready  = (cnt != (AW+1)'(FIFO_DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = (state == S_ISSUE);
    assign add_start = (state == S_ISSUE);
    assign add_rst   = (state == S_INIT) || tmo_hit;
    assign busy      = not_empty || (state != S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_a[wptr] <= in_a;
                mem_b[wptr] <= in_b;
                wptr        <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign tmo_hit = (state == S_WAIT) && !add_done &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end else begin
                tmo_cnt <= '0;
            end
            if (tmo_hit) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_INIT:  state_nx = S_IDLE;
            S_IDLE:  if (not_empty) state_nx = S_ISSUE;
            S_ISSUE: state_nx = S_WAIT;
            S_WAIT: begin
                if (add_done) begin
                    state_nx = S_HOLD;
                end else if (tmo_hit) begin
                    state_nx = S_IDLE;
                end
            end
            S_HOLD:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_INIT;
        endcase
    end

    // Operands load on entry to ISSUE so they are already stable while add_start is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_a     <= '0;
            add_b     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            ops_count <= '0;
        end else begin
            if (state == S_IDLE && not_empty) begin
                add_a <= mem_a[rptr];
                add_b <= mem_b[rptr];
            end
            if (state == S_WAIT && add_done) begin
                out_sum   <= add_c;
                out_valid <= 1'b1;
            end
            if (state == S_HOLD && out_ready) begin
                out_valid <= 1'b0;
                ops_count <= ops_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_sequencer.sv
// Directed bench for serial_adder_sequencer with a behavioural 3-cycle adder.
// Covers reset, single op, overflow, backpressure, FIFO wrap, reset mid-op, timeout.
`timescale 1ns/1ps
module tb_serial_adder_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_a, in_b, out_sum, add_a, add_b, add_c;
    logic [15:0] ops_count;
    logic        busy, err, add_start, add_rst, add_done;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  results [$];
    int          starts = 0;
    int          arst = 0;
    bit          start_in_hold = 1'b0;
    bit          adder_en = 1'b1;
    logic [7:0]  pa;
    int          acnt;

    serial_adder_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .ops_count (ops_count),
        .busy      (busy),
        .err       (err),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_start (add_start),
        .add_rst   (add_rst),
        .add_c     (add_c),
        .add_done  (add_done)
    );

    always #5 clk = ~clk;

    // Behavioural adder: done pulse three edges after a sampled start.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            add_done <= 1'b0;
            add_c    <= '0;
            acnt     <= 0;
            pa       <= '0;
        end else begin
            add_done <= 1'b0;
            if (add_rst) begin
                acnt <= 0;
            end else if (add_start && adder_en) begin
                pa   <= add_a + add_b;
                acnt <= 3;
            end else if (acnt != 0) begin
                acnt <= acnt - 1;
                if (acnt == 1) begin
                    add_done <= 1'b1;
                    add_c    <= pa;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            if (add_start) starts++;
            if (add_start && out_valid) start_in_hold = 1'b1;
            if (add_rst) arst++;
            if (out_valid && out_ready) results.push_back(out_sum);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int k = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!in_ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("push_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (results.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("result_count", 32'(results.size()), 32'(n));
    endtask

    initial begin
        logic [7:0] ea, eb;
        int s0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_sum",   32'(out_sum),   32'd0);
        chk("rst_ops_count", 32'(ops_count), 32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_add_a",     32'(add_a),     32'd0);
        chk("rst_add_b",     32'(add_b),     32'd0);
        chk("rst_add_start", 32'(add_start), 32'd0);
        chk("rst_add_rst",   32'(add_rst),   32'd1);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst = 1'b1;
        #1;
        chk("init_add_rst", 32'(add_rst), 32'd1);
        @(negedge clk);
        chk("idle_add_rst", 32'(add_rst), 32'd0);
        chk("idle_busy",    32'(busy),    32'd0);

        // Single operation
        out_ready = 1'b1;
        push(8'h3C, 8'h15);
        chk("pre_issue_start", 32'(add_start), 32'd0);
        @(negedge clk);
        chk("issue_start", 32'(add_start), 32'd1);
        chk("issue_add_a", 32'(add_a),     32'h3C);
        chk("issue_add_b", 32'(add_b),     32'h15);
        @(negedge clk);
        chk("wait_start_low", 32'(add_start), 32'd0);
        wait_results(1);
        chk("single_sum",    32'(results[0]), 32'h51);
        chk("single_ops",    32'(ops_count),  32'd1);
        chk("single_starts", 32'(starts),     32'd1);
        @(negedge clk);
        chk("single_busy", 32'(busy), 32'd0);

        // Carry out discarded
        push(8'hFF, 8'h01);
        push(8'h80, 8'h80);
        wait_results(3);
        chk("ovf_sum0", 32'(results[1]), 32'h00);
        chk("ovf_sum1", 32'(results[2]), 32'h00);
        chk("ovf_ops",  32'(ops_count),  32'd3);

        // Backpressure: one op parks in HOLD, FIFO fills, sixth waits
        out_ready = 1'b0;
        s0 = starts;
        for (int i = 1; i <= 5; i++) begin
            ea = 8'(i);
            eb = 8'(i * 16);
            push(ea, eb);
        end
        in_valid = 1'b1;
        in_a     = 8'h06;
        in_b     = 8'h60;
        repeat (4) @(negedge clk);
        chk("bp_in_ready",  32'(in_ready),  32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_out_sum",   32'(out_sum),   32'h11);
        chk("bp_busy",      32'(busy),      32'd1);
        chk("bp_one_start", 32'(starts - s0), 32'd1);
        out_ready = 1'b1;
        push(8'h06, 8'h60);
        wait_results(9);
        for (int i = 1; i <= 6; i++) begin
            chk("bp_order", 32'(results[2 + i]), 32'(8'(i * 8'h11)));
        end
        chk("bp_ops",        32'(ops_count),     32'd9);
        chk("start_in_hold", 32'(start_in_hold), 32'd0);

        // Continuous pushes, pointers wrap several times
        for (int i = 0; i < 8; i++) begin
            ea = 8'(i * 37 + 200);
            eb = 8'(i * 13 + 90);
            push(ea, eb);
        end
        wait_results(17);
        for (int i = 0; i < 8; i++) begin
            ea = 8'(i * 37 + 200);
            eb = 8'(i * 13 + 90);
            chk("stream_sum", 32'(results[9 + i]), 32'(8'(ea + eb)));
        end
        chk("stream_ops",    32'(ops_count), 32'd17);
        chk("stream_starts", 32'(starts),    32'd17);

        // Reset while WAIT with two entries queued
        adder_en = 1'b0;
        push(8'h11, 8'h22);
        push(8'h33, 8'h44);
        push(8'h55, 8'h66);
        repeat (3) @(negedge clk);
        chk("mid_busy",  32'(busy),  32'd1);
        chk("mid_add_a", 32'(add_a), 32'h11);
        rst = 1'b0;
        #1;
        chk("mid_rst_ops",      32'(ops_count), 32'd0);
        chk("mid_rst_add_a",    32'(add_a),     32'd0);
        chk("mid_rst_add_rst",  32'(add_rst),   32'd1);
        chk("mid_rst_in_ready", 32'(in_ready),  32'd1);
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        @(negedge clk);
        adder_en = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_init_add_rst", 32'(add_rst), 32'd1);
        repeat (10) @(negedge clk);
        chk("mid_no_result", 32'(results.size()), 32'd17);
        chk("mid_add_rst",   32'(add_rst),        32'd0);
        chk("mid_busy_done", 32'(busy),           32'd0);
        chk("mid_ops",       32'(ops_count),      32'd0);

        // Adder never answers
        adder_en = 1'b0;
        arst = 0;
        push(8'h12, 8'h34);
        repeat (30) @(negedge clk);
`ifdef SEQ_TIMEOUT_EN
        chk("tmo_err",    32'(err),       32'd1);
        chk("tmo_pulses", 32'(arst),      32'd1);
        chk("tmo_busy",   32'(busy),      32'd0);
        chk("tmo_ops",    32'(ops_count), 32'd0);
`else
        chk("notmo_err",    32'(err),  32'd0);
        chk("notmo_busy",   32'(busy), 32'd1);
        chk("notmo_pulses", 32'(arst), 32'd0);
`endif
        chk("tmo_no_result", 32'(results.size()), 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
